// File: rtl/rx_to_mem.sv
// UART byte receiver feeding a row-major matrix loader.
// Each accepted byte becomes one memory write while a load is active.
module rx_to_mem #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int ROWS         = 2,
    parameter int COLUMNS      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    input  logic       load_mat,
    output logic       write,
    output logic [5:0] write_address,
    output logic [7:0] write_value,
    output logic       busy,
    output logic       load_done,
    output logic       frame_err
);

    localparam int TOTAL = ROWS * COLUMNS;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int TW    = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TW-1:0] T_FULL  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(HALF - 1);
    localparam logic [6:0]    N_TOTAL = 7'(TOTAL);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_WAIT,
        L_LOAD,
        L_DONE
    } ld_state_t;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    rx_state_t       r_rstate;
    rx_state_t       w_rnext;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bitn;
    logic [7:0]      r_shift;
    logic            w_tclr;
    logic            w_sample;
    logic            w_byte_ok;
    logic            w_byte_bad;

    ld_state_t       r_lstate;
    ld_state_t       w_lnext;
    logic            r_load_prev;
    logic            w_load_rise;
    logic [6:0]      r_count;
    logic            w_start;
    logic            w_wr;

    // Two-flop synchronizer; r_rx_prev gives the falling-edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_data;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext    = r_rstate;
        w_tclr     = 1'b0;
        w_sample   = 1'b0;
        w_byte_ok  = 1'b0;
        w_byte_bad = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (r_rx_prev && !r_sync2) begin
                    w_rnext = R_START;
                    w_tclr  = 1'b1;
                end
            end
            R_START: begin
                if (r_timer == T_HALF) begin
                    w_tclr  = 1'b1;
                    w_rnext = r_sync2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_timer == T_FULL) begin
                    w_tclr   = 1'b1;
                    w_sample = 1'b1;
                    if (r_bitn == 3'd7) begin
                        w_rnext = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (r_timer == T_FULL) begin
                    w_tclr  = 1'b1;
                    w_rnext = R_IDLE;
                    if (r_sync2) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_byte_bad = 1'b1;
                    end
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_bitn  <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            if (r_rstate == R_IDLE || w_tclr) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_rstate == R_START) begin
                r_bitn <= 3'd0;
            end else if (w_sample) begin
                r_bitn <= r_bitn + 3'd1;
            end
            // LSB arrives first, so shift in from the top
            if (w_sample) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    assign w_load_rise = load_mat & ~r_load_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lstate    <= L_WAIT;
            r_load_prev <= 1'b0;
        end else begin
            r_lstate    <= w_lnext;
            r_load_prev <= load_mat;
        end
    end

    always_comb begin
        w_lnext = r_lstate;
        w_start = 1'b0;
        w_wr    = 1'b0;
        unique case (r_lstate)
            L_WAIT: begin
                if (w_load_rise) begin
                    w_lnext = L_LOAD;
                    w_start = 1'b1;
                end
            end
            L_LOAD: begin
                if (w_byte_ok) begin
                    w_wr = 1'b1;
                    if (r_count + 7'd1 == N_TOTAL) begin
                        w_lnext = L_DONE;
                    end
                end
            end
            L_DONE: w_lnext = L_WAIT;
            default: w_lnext = L_WAIT;
        endcase
    end

    // Address and data only move on a write, so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count       <= 7'd0;
            write         <= 1'b0;
            write_address <= 6'd0;
            write_value   <= 8'd0;
            frame_err     <= 1'b0;
        end else begin
            write     <= w_wr;
            frame_err <= w_byte_bad;
            if (w_start) begin
                r_count <= 7'd0;
            end else if (w_wr) begin
                r_count <= r_count + 7'd1;
            end
            if (w_wr) begin
                write_address <= r_count[5:0];
                write_value   <= r_shift;
            end
        end
    end

    assign busy      = (r_lstate == L_LOAD);
    assign load_done = (r_lstate == L_DONE);

endmodule

// File: tb/tb_rx_to_mem.sv
// Bench for rx_to_mem: serial stimulus against a load/counter model.
// Writes, frame errors and done pulses are collected by a monitor.
module tb_rx_to_mem;

    localparam int CPB   = 16;
    localparam int TOTAL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_data = 1'b1;
    logic       load_mat = 1'b0;
    logic       write;
    logic [5:0] write_address;
    logic [7:0] write_value;
    logic       busy;
    logic       load_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];
    int got_fe = 0;
    int got_done = 0;
    int exp_fe = 0;
    int exp_done = 0;

    bit m_loading = 0;
    int m_cnt = 0;

    rx_to_mem #(
        .CLKS_PER_BIT(CPB),
        .ROWS(2),
        .COLUMNS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .load_mat(load_mat),
        .write(write),
        .write_address(write_address),
        .write_value(write_value),
        .busy(busy),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (write) got_q.push_back({write_address, write_value});
            if (frame_err) got_fe++;
            if (load_done) got_done++;
        end
    end

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        got_fe = 0;
        got_done = 0;
        exp_fe = 0;
        exp_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_data = 1'b1;
        load_mat = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_loading = 0;
        m_cnt = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_load();
        load_mat = 1'b1;
        repeat (2) @(negedge clk);
        load_mat = 1'b0;
        repeat (2) @(negedge clk);
        if (!m_loading) begin
            m_loading = 1;
            m_cnt = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx_data = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_data = stop_ok;
        repeat (CPB) @(negedge clk);
        rx_data = 1'b1;
        repeat (6) @(negedge clk);
        if (!stop_ok) begin
            exp_fe++;
        end else if (m_loading) begin
            exp_q.push_back({6'(m_cnt), b});
            m_cnt++;
            if (m_cnt == TOTAL) begin
                m_loading = 0;
                exp_done++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (write !== 1'b0) begin
            $display("FAIL reset_write got %b exp 0", write); errors++;
        end
        checks++;
        if (write_address !== 6'd0) begin
            $display("FAIL reset_addr got %0d exp 0", write_address); errors++;
        end
        checks++;
        if (write_value !== 8'd0) begin
            $display("FAIL reset_value got %h exp 00", write_value); errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy got %b exp 0", busy); errors++;
        end
        checks++;
        if (load_done !== 1'b0) begin
            $display("FAIL reset_done got %b exp 0", load_done); errors++;
        end
        checks++;
        if (frame_err !== 1'b0) begin
            $display("FAIL reset_ferr got %b exp 0", frame_err); errors++;
        end
        do_reset();
    endtask

    task automatic test_basic_load();
        clear_obs();
        pulse_load();
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy_up got %b exp 1", busy); errors++;
        end
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL basic_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
        checks++;
        if (got_done != exp_done) begin
            $display("FAIL basic_done got %0d exp %0d", got_done, exp_done); errors++;
        end
        checks++;
        if (busy !== m_loading) begin
            $display("FAIL basic_busy got %b exp %b", busy, m_loading); errors++;
        end
    endtask

    task automatic test_no_load();
        clear_obs();
        send_byte(8'hA5, 1);
        checks++;
        if (got_q.size() != 0) begin
            $display("FAIL noload_writes got %0d exp 0", got_q.size()); errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL noload_busy got %b exp 0", busy); errors++;
        end
    endtask

    task automatic test_frame_err();
        clear_obs();
        pulse_load();
        send_byte(8'h5A, 0);
        send_byte(8'h77, 1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
        checks++;
        if (got_fe != 1) begin
            $display("FAIL frame_count got %0d exp 1", got_fe); errors++;
        end
        checks++;
        if (got_q.size() == 0 || got_q[0] !== {6'd0, 8'h77}) begin
            $display("FAIL frame_first got %h exp %h",
                     got_q.size() ? got_q[0] : 14'h3fff, {6'd0, 8'h77}); errors++;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL frame_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL frame_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        pulse_load();
        rx_data = 1'b0;
        repeat (4) @(negedge clk);
        rx_data = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || got_fe != 0) begin
            $display("FAIL glitch_quiet got wr=%0d fe=%0d exp 0/0", got_q.size(), got_fe); errors++;
        end
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL glitch_busy got %b exp 1", busy); errors++;
        end
        for (int i = 0; i < TOTAL; i++) send_byte(8'($urandom), 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL glitch_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL glitch_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        pulse_load();
        send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 1);
        rx_data = 1'b0;
        repeat (50) @(negedge clk);
        do_reset();
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL rstmid_busy got %b exp 0", busy); errors++;
        end
        pulse_load();
        for (int i = 0; i < TOTAL; i++) send_byte(8'($urandom), 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL rstmid_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rstmid_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
        checks++;
        if (got_done != exp_done) begin
            $display("FAIL rstmid_done got %0d exp %0d", got_done, exp_done); errors++;
        end
    endtask

    task automatic test_reload_busy();
        clear_obs();
        pulse_load();
        send_byte(8'($urandom), 1);
        pulse_load();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL reload_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL reload_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
        checks++;
        if (got_done != 1 || busy !== 1'b0) begin
            $display("FAIL reload_end got done=%0d busy=%b exp 1/0", got_done, busy); errors++;
        end
    endtask

    task automatic test_held_load();
        clear_obs();
        load_mat = 1'b1;
        repeat (4) @(negedge clk);
        if (!m_loading) begin
            m_loading = 1;
            m_cnt = 0;
        end
        for (int i = 0; i < TOTAL + 2; i++) send_byte(8'($urandom), 1);
        load_mat = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL held_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        checks++;
        if (got_done != 1) begin
            $display("FAIL held_done got %0d exp 1", got_done); errors++;
        end
    endtask

    task automatic test_random();
        int r;
        clear_obs();
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) pulse_load();
            else if (r < 3) send_byte(8'($urandom), 0);
            else send_byte(8'($urandom), 1);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL rand_nwr got %0d exp %0d", got_q.size(), exp_q.size()); errors++;
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                $display("FAIL rand_write%0d got %h exp %h", i, got_q[i], exp_q[i]); errors++;
            end
        end
        checks++;
        if (got_fe != exp_fe) begin
            $display("FAIL rand_fe got %0d exp %0d", got_fe, exp_fe); errors++;
        end
        checks++;
        if (got_done != exp_done) begin
            $display("FAIL rand_done got %0d exp %0d", got_done, exp_done); errors++;
        end
        checks++;
        if (busy !== m_loading) begin
            $display("FAIL rand_busy got %b exp %b", busy, m_loading); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_no_load();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_reload_busy();
        test_held_load();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_to_mem.md
RX_TO_MEM -- requirements
Module: rx_to_mem

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clk cycles per UART bit (9600 baud at 100 MHz).
REQ-002 SHALL have parameter ROWS, default 2, matrix rows.
REQ-003 SHALL have parameter COLUMNS, default 2, matrix columns; ROWS*COLUMNS SHALL be at most 64.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port rx_data, input, 1 bit, asynchronous UART serial line, idle high.
REQ-007 SHALL have port load_mat, input, 1 bit, level request to load one matrix.
REQ-008 SHALL have port write, output, 1 bit, one-cycle memory write strobe.
REQ-009 SHALL have port write_address, output, 6 bits, memory write address.
REQ-010 SHALL have port write_value, output, 8 bits, memory write data.
REQ-011 SHALL have port busy, output, 1 bit, high while a matrix load is in progress.
REQ-012 SHALL have port load_done, output, 1 bit, one-cycle pulse when the last element is written.
REQ-013 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.

Function
REQ-014 SHALL pass rx_data through a 2-flop synchronizer before any use.
REQ-015 SHALL run the receiver FSM with states R_IDLE, R_START, R_DATA and R_STOP.
REQ-016 R_IDLE: on a synchronized falling edge (1 then 0), SHALL go to R_START and clear the bit-timer.
REQ-017 R_START: at CLKS_PER_BIT/2 cycles, SHALL go to R_DATA if the line is still low, else return to R_IDLE (glitch reject, no error).
REQ-018 R_DATA: SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample, then go to R_STOP.
REQ-019 R_STOP: CLKS_PER_BIT cycles after the last data sample, a high line SHALL mark the byte valid; a low line SHALL pulse frame_err and discard the byte; either way the FSM returns to R_IDLE.
REQ-020 SHALL run the loader FSM with states L_WAIT, L_LOAD and L_DONE.
REQ-021 L_WAIT: SHALL edge-detect load_mat inside the clk domain; a rising edge SHALL clear the element counter, set busy and go to L_LOAD.
REQ-022 L_LOAD: each valid byte SHALL assert write for exactly one cycle, the cycle after the stop-bit sample, with write_address = counter and write_value = byte; the counter then increments.
REQ-023 Write order SHALL be row-major: element (r,c) goes to address r*COLUMNS+c.
REQ-024 When the counter reaches ROWS*COLUMNS after a write, SHALL go to L_DONE; L_DONE SHALL pulse load_done for one cycle, clear busy and return to L_WAIT.
REQ-025 Valid bytes received in L_WAIT or L_DONE SHALL be discarded with no write.
REQ-026 A framing-error byte SHALL leave the counter unchanged and produce no write.
REQ-027 A load_mat rising edge while busy SHALL be ignored.
REQ-028 A load_mat held high SHALL start only one load.
REQ-029 write_address and write_value SHALL hold their last values when write is low.
REQ-030 The counter SHALL be 7 bits wide so that a 64-element load terminates without wrap.

Reset
REQ-031 rst SHALL force both FSMs to R_IDLE/L_WAIT and set the counter to 0.
REQ-032 rst SHALL set write=0, write_address=0, write_value=0, busy=0, load_done=0 and frame_err=0.
REQ-033 rst SHALL set the synchronizer flops to 1.
REQ-034 A reset mid-byte or mid-load SHALL abandon the byte and load with no further write; a partial matrix in memory is acceptable.

Verification (CLKS_PER_BIT=16, ROWS=COLUMNS=2)
REQ-035 Pulse load_mat, then send bytes 0x11, 0x22, 0x33, 0x44 -> writes to addresses 0, 1, 2, 3 with those values; load_done pulses once after the 4th write; busy falls.
REQ-036 Send 0xA5 with no load_mat -> no write, busy stays 0.
REQ-037 During a load, send 0x5A with stop bit 0, then 0x77 -> frame_err pulses once; 0x77 is written to address 0.
REQ-038 Drive rx_data low for 4 cycles during a load -> no write, no frame_err, counter stays 0.
REQ-039 Assert rst after 2 of 4 bytes, then pulse load_mat and send 4 bytes -> writes restart at address 0; exactly 4 writes follow.
REQ-040 Re-pulse load_mat while busy after 1 byte -> the counter is not cleared; the remaining 3 bytes go to addresses 1..3.
